// File: rtl/scaler_pipe_catch_pkg.sv
// Shared scaler_dsp constants: a clog2 helper and the per-stage pipeline latencies.
package scaler_pipe_catch_pkg;

   // Ceiling log2, usable in constant expressions.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // DSP stage latencies in clock cycles.
   localparam int unsigned LatScaleMul = 3;
   localparam int unsigned LatScaleRnd = 1;
   localparam int unsigned LatScaler   = LatScaleMul + LatScaleRnd;

   // Catch buffer must hold everything in flight plus one for full throughput.
   localparam int unsigned CatchDepth  = 1 << clog2(LatScaler + 1);

endpackage

// File: rtl/scaler_pipe_catch_ram.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module scaler_pipe_catch_ram
   import scaler_pipe_catch_pkg::*;
#(
   parameter int unsigned BitWidth = 8,
   parameter int unsigned Depth    = 8,
   localparam int unsigned AddrW   = clog2(Depth)
) (
   input  logic                clk_i,
   input  logic                wr_en_i,
   input  logic [AddrW-1:0]    wr_addr_i,
   input  logic [BitWidth-1:0] wr_data_i,
   input  logic [AddrW-1:0]    rd_addr_i,
   output logic [BitWidth-1:0] rd_data_o
);

   logic [BitWidth-1:0] mem_q [Depth];

   // Storage array, written on push when the word does not bypass to the output register.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/scaler_pipe_catch.sv
// Catches words from a non-stalling fixed-latency pipeline and hands them to a valid/ready
// consumer; issue credits bound the words in flight so the buffer cannot overflow.
module scaler_pipe_catch
   import scaler_pipe_catch_pkg::*;
#(
   parameter int unsigned BitWidth = 8,
   parameter int unsigned Depth    = CatchDepth,
   localparam int unsigned CntW    = clog2(Depth) + 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                issue_valid_i,
   output logic                issue_ready_o,
   input  logic                pipe_valid_i,
   input  logic [BitWidth-1:0] pipe_data_i,
   output logic                m_valid_o,
   output logic [BitWidth-1:0] m_data_o,
   input  logic                m_ready_i,
   output logic [CntW-1:0]     level_o,
   output logic [CntW-1:0]     credits_o,
   output logic                ovf_err_o,
   output logic                unf_err_o
);

   localparam int unsigned AddrW = clog2(Depth);
   localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

   logic [CntW-1:0]     credits_q, credits_d, level_q, level_d;
   logic [AddrW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic                m_valid_q, m_valid_d;
   logic [BitWidth-1:0] m_data_q, m_data_d, rd_data;
   logic                ovf_q, ovf_d, unf_q, unf_d;
   logic                issue, pop, full, push, mem_empty, out_load, load_mem, bypass, wr_en;

   assign issue_ready_o = (credits_q != '0);
   assign issue         = issue_valid_i & issue_ready_o;
   assign pop           = m_valid_q & m_ready_i;
   assign full          = (level_q == DepthCnt);
   // A pop in the same cycle frees the slot, so a full buffer still accepts the word.
   assign push          = pipe_valid_i & (~full | pop);
   // The output register is always filled first, so the array holds level minus that slot.
   assign mem_empty     = (level_q == CntW'(m_valid_q));
   assign out_load      = ~m_valid_q | pop;
   assign load_mem      = out_load & ~mem_empty;
   assign bypass        = out_load & mem_empty & push;
   assign wr_en         = push & ~bypass;

   // Next-state for counters, pointers, output register and sticky error flags.
   always_comb begin
      credits_d = credits_q;
      if (issue && !pop)      credits_d = credits_q - 1'b1;
      else if (pop && !issue) credits_d = credits_q + 1'b1;

      level_d = level_q;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;

      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      rptr_d    = rptr_q;
      wptr_d    = wptr_q;
      if (load_mem) begin
         m_valid_d = 1'b1;
         m_data_d  = rd_data;
         rptr_d    = rptr_q + 1'b1;
      end else if (bypass) begin
         m_valid_d = 1'b1;
         m_data_d  = pipe_data_i;
      end else if (out_load) begin
         m_valid_d = 1'b0;
      end
      if (wr_en) wptr_d = wptr_q + 1'b1;

      ovf_d = ovf_q | (pipe_valid_i & full & ~pop);
      unf_d = unf_q | (issue_valid_i & ~issue_ready_o);
   end

   // State registers; reset discards all stored words and clears the error flags.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         credits_q <= DepthCnt;
         level_q   <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         credits_q <= credits_d;
         level_q   <= level_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   scaler_pipe_catch_ram #(
      .BitWidth (BitWidth),
      .Depth    (Depth)
   ) u_ram (
      .clk_i     (clk_i),
      .wr_en_i   (wr_en),
      .wr_addr_i (wptr_q),
      .wr_data_i (pipe_data_i),
      .rd_addr_i (rptr_q),
      .rd_data_o (rd_data)
   );

   assign m_valid_o = m_valid_q;
   assign m_data_o  = m_data_q;
   assign level_o   = level_q;
   assign credits_o = credits_q;
   assign ovf_err_o = ovf_q;
   assign unf_err_o = unf_q;

endmodule

// File: tb/tb_scaler_pipe_catch.sv
// Directed bench: a 4-cycle pipeline model feeds the catcher, a monitor collects popped words.
module tb_scaler_pipe_catch;
   import scaler_pipe_catch_pkg::*;

   localparam int unsigned Lat   = 4;
   localparam int unsigned Depth = 8;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b1;
   logic       issue_valid = 1'b0, issue_ready;
   logic       pipe_valid;
   logic [7:0] pipe_data;
   logic       m_valid, m_ready = 1'b0;
   logic [7:0] m_data;
   logic [3:0] level, credits;
   logic       ovf_err, unf_err;

   logic [7:0] iss_data = 8'h00;
   logic       inj_valid = 1'b0;
   logic [7:0] inj_data = 8'h00;
   logic       inv_en = 1'b0;
   logic [3:0] lvl_max = 4'd0;
   logic [Lat-1:0] pv_q;
   logic [7:0] pd_q [Lat];
   logic [7:0] got_q [$];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   scaler_pipe_catch #(
      .BitWidth (8),
      .Depth    (Depth)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .issue_valid_i (issue_valid),
      .issue_ready_o (issue_ready),
      .pipe_valid_i  (pipe_valid),
      .pipe_data_i   (pipe_data),
      .m_valid_o     (m_valid),
      .m_data_o      (m_data),
      .m_ready_i     (m_ready),
      .level_o       (level),
      .credits_o     (credits),
      .ovf_err_o     (ovf_err),
      .unf_err_o     (unf_err)
   );

   // Fixed-latency pipeline model; injection overrides the tail to force protocol cases.
   assign pipe_valid = pv_q[Lat-1] | inj_valid;
   assign pipe_data  = inj_valid ? inj_data : pd_q[Lat-1];

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pv_q <= '0;
         for (int i = 0; i < Lat; i++) pd_q[i] <= 8'h00;
      end else begin
         pv_q    <= {pv_q[Lat-2:0], issue_valid & issue_ready};
         pd_q[0] <= iss_data;
         for (int i = 1; i < Lat; i++) pd_q[i] <= pd_q[i-1];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Popped-word monitor and credit/level/in-flight conservation.
   always @(negedge clk_i) begin
      if (rst_ni && m_valid && m_ready) got_q.push_back(m_data);
      if (rst_ni && level > lvl_max) lvl_max = level;
      if (rst_ni && inv_en)
         check("invariant", 32'(credits) + 32'(level) + 32'($countones(pv_q)), Depth);
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      issue_valid = 1'b0;
      inj_valid = 1'b0;
      m_ready = 1'b0;
      #2;
      check("rst_m_valid", 32'(m_valid), 0);
      check("rst_m_data", 32'(m_data), 0);
      check("rst_level", 32'(level), 0);
      check("rst_credits", 32'(credits), Depth);
      check("rst_issue_ready", 32'(issue_ready), 1);
      check("rst_errs", {30'd0, ovf_err, unf_err}, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();
   endtask

   // Issue up to n words whenever a credit is available, within a cycle budget.
   task automatic run_issue(input int n, input logic [7:0] first, input int cycles,
                            output int sent, output int stalls);
      sent = 0;
      stalls = 0;
      for (int c = 0; c < cycles && sent < n; c++) begin
         issue_valid = issue_ready;
         if (!issue_ready) stalls++;
         iss_data = 8'(32'(first) + sent);
         tick();
         if (issue_valid) sent++;
      end
      issue_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int c;
      c = 0;
      m_ready = 1'b1;
      while ((level != 0 || pv_q != 0) && c < 60) begin
         tick();
         c++;
      end
      check(tag, 32'(level), 0);
   endtask

   initial begin
      int sent, stalls;
      #1;
      do_reset();
      inv_en = 1'b1;

      // Streaming at full rate.
      got_q.delete();
      lvl_max = 4'd0;
      m_ready = 1'b1;
      run_issue(20, 8'h00, 40, sent, stalls);
      check("t1_sent", sent, 20);
      check("t1_stalls", stalls, 0);
      drain("t1_drain");
      check("t1_count", got_q.size(), 20);
      if (got_q.size() == 20)
         for (int i = 0; i < 20; i++) check("t1_data", 32'(got_q[i]), i);
      check("t1_level_le2", 32'(lvl_max <= 4'd2), 1);

      // Backpressure: credits stop issue at exactly Depth words.
      got_q.delete();
      m_ready = 1'b0;
      run_issue(12, 8'h00, 14, sent, stalls);
      check("t2_sent", sent, 8);
      repeat (Lat + 1) tick();
      check("t2_issue_ready", 32'(issue_ready), 0);
      check("t2_level", 32'(level), 8);
      check("t2_credits", 32'(credits), 0);
      check("t2_errs", {30'd0, ovf_err, unf_err}, 0);
      drain("t2_drain");
      check("t2_count", got_q.size(), 8);
      if (got_q.size() == 8)
         for (int i = 0; i < 8; i++) check("t2_data", 32'(got_q[i]), i);
      check("t2_credits_back", 32'(credits), 8);

      // Stall stability and single-pulse pop.
      got_q.delete();
      m_ready = 1'b0;
      run_issue(2, 8'h5A, 4, sent, stalls);
      repeat (Lat + 1) tick();
      check("t4_m_valid", 32'(m_valid), 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t4_hold", 32'(m_data), 32'h5A);
      end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check("t4_next", 32'(m_data), 32'h5B);
      check("t4_level", 32'(level), 1);
      check("t4_popped", got_q.size(), 1);
      tick();
      check("t4_level_hold", 32'(level), 1);
      drain("t4_drain");

      // Full buffer with push and pop in the same cycle.
      got_q.delete();
      m_ready = 1'b0;
      run_issue(8, 8'h00, 12, sent, stalls);
      repeat (Lat + 1) tick();
      check("t3_full", 32'(level), 8);
      inv_en = 1'b0;
      m_ready = 1'b1;
      inj_valid = 1'b1;
      inj_data = 8'hA5;
      tick();
      inj_valid = 1'b0;
      m_ready = 1'b0;
      check("t3_level", 32'(level), 8);
      check("t3_ovf", 32'(ovf_err), 0);
      check("t3_head", 32'(m_data), 1);
      drain("t3_drain");
      check("t3_count", got_q.size(), 9);
      if (got_q.size() == 9) begin
         for (int i = 0; i < 8; i++) check("t3_data", 32'(got_q[i]), i);
         check("t3_last", 32'(got_q[8]), 32'hA5);
      end
      // One-cycle latency into an empty buffer, no combinational path.
      m_ready = 1'b0;
      inj_valid = 1'b1;
      inj_data = 8'h3C;
      #1;
      check("lat_no_comb", 32'(m_valid), 0);
      tick();
      inj_valid = 1'b0;
      check("lat_valid", 32'(m_valid), 1);
      check("lat_data", 32'(m_data), 32'h3C);

      // Error injection: overflow drops the word, issue without credit flags underflow.
      do_reset();
      inv_en = 1'b1;
      got_q.delete();
      run_issue(8, 8'h00, 12, sent, stalls);
      repeat (Lat + 1) tick();
      check("t5_full", 32'(level), 8);
      inj_valid = 1'b1;
      inj_data = 8'hEE;
      tick();
      inj_valid = 1'b0;
      check("t5_ovf", 32'(ovf_err), 1);
      check("t5_level", 32'(level), 8);
      issue_valid = 1'b1;
      tick();
      issue_valid = 1'b0;
      check("t5_unf", 32'(unf_err), 1);
      check("t5_credits", 32'(credits), 0);
      drain("t5_drain");
      check("t5_count", got_q.size(), 8);
      if (got_q.size() == 8) check("t5_last", 32'(got_q[7]), 7);
      check("t5_credits_back", 32'(credits), 8);
      check("t5_ovf_sticky", 32'(ovf_err), 1);

      // Reset mid-burst, then restart.
      do_reset();
      run_issue(5, 8'h40, 8, sent, stalls);
      repeat (Lat + 1) tick();
      check("t6_level", 32'(level), 5);
      do_reset();
      got_q.delete();
      m_ready = 1'b1;
      run_issue(4, 8'h70, 8, sent, stalls);
      drain("t6_drain");
      check("t6_count", got_q.size(), 4);
      if (got_q.size() == 4)
         for (int i = 0; i < 4; i++) check("t6_data", 32'(got_q[i]), 32'h70 + i);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/scaler_pipe_catch.md
Name: scaler_pipe_catch

Overview:
Receive-side companion to the fixed-latency scaler DSP delay pipelines. Catches words leaving a fixed-latency pipeline that cannot stall, and buffers them toward a downstream valid/ready consumer. Grants issue credits back to the pipeline entry so that in-flight words can never overflow the buffer. Sits between the scaler_dsp pipeline tail and the line/output stage.

Parameters:
BITWIDTH, 8, data word width
DEPTH, 8, buffer entries; power of two; must be >= pipeline latency + 1 for full throughput
CNTW, clog2(DEPTH)+1, width of the occupancy and credit counters (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
issue_valid  in  1  pipeline entry has a word to issue this cycle
issue_ready  out  1  a credit is available; the entry may issue
pipe_valid  in  1  word emerging from the pipeline tail
pipe_data  in  BITWIDTH  tail data
m_valid  out  1  output word valid
m_data  out  BITWIDTH  output data
m_ready  in  1  downstream accepts
level  out  CNTW  words currently stored (including the output register)
credits  out  CNTW  credits remaining
ovf_err  out  1  sticky: a word arrived while the buffer was full
unf_err  out  1  sticky: an issue occurred with zero credits

Behaviour:
- Reset (async assert, sync release) sets these values:
  - credits = DEPTH, issue_ready = 1
  - level = 0, m_valid = 0, m_data = 0
  - read/write pointers = 0
  - ovf_err = 0, unf_err = 0
- issue = issue_valid & issue_ready. pop = m_valid & m_ready.
- Credit counter, per cycle:
  - -1 on issue only; +1 on pop only; unchanged when both occur.
  - issue_ready = (credits != 0), registered-equivalent (derived from the credit register only, with no combinational path from m_ready).
- Push happens on pipe_valid. The catcher has no ready toward the pipe; the word is always written.
  - If level == DEPTH and no pop this cycle, the word is dropped and ovf_err is set.
  - If level == DEPTH and pop occurs the same cycle, the push is accepted. Level stays at DEPTH.
- Storage is a circular buffer of DEPTH entries plus a show-ahead output register.
  - Pointers wrap modulo DEPTH.
  - Level changes by +1 on push only, -1 on pop only, and is unchanged on both.
- Latency: a pipe_valid at cycle N into an empty buffer gives m_valid = 1 with that data at cycle N+1. There is no combinational pipe-to-m path.
- Output handshake:
  - m_data holds stable while m_valid & !m_ready.
  - After a pop, the next stored word appears the following cycle with no bubble when level > 1.
- An issue with credits == 0 (an upstream protocol violation) sets unf_err. Credits saturate at 0.
- Error flags clear only on reset.
- Reset mid-operation: all in-flight and stored words are discarded, and every output takes its reset value immediately.
- Invariant for the bench: credits + level + in-flight == DEPTH at every cycle, in the absence of errors.

Decomposition:
- Shared scaler_dsp header: a clog2 constant function and the pipeline latency constants per DSP stage. The top instance sets DEPTH from these.
- One natural sub-module: pipe_catch_ram. A DEPTH x BITWIDTH simple dual-port register array with a synchronous write port and an asynchronous read port, indexed by the pointers.
- The credit counter and output register stay in scaler_pipe_catch.

Test Plan:
1. Streaming: DEPTH=8, pipeline latency 4, m_ready=1, issue 20 words 0x00..0x13 back-to-back -> issue_ready never drops, m_data emits 0x00..0x13 in order, level <= 2.
2. Backpressure: m_ready=0, issue continuously -> exactly 8 issues accepted, then issue_ready=0. All 8 words land, level=8, ovf_err=0. Raise m_ready -> 0x00..0x07 out in order, credits return to 8.
3. Simultaneous full push/pop: level=8, pipe_valid and pop in the same cycle -> level stays 8, the new word is stored after the others, and ordering is preserved.
4. Stall stability: m_valid=1 with m_data=0x5A and m_ready=0 for 5 cycles -> m_data stays 0x5A; a single m_ready pulse pops exactly one word.
5. Error injection: force pipe_valid with level=8 and no pop -> ovf_err=1 and the word is dropped. Force issue_valid with credits=0 -> unf_err=1, credits stay 0.
6. Reset mid-burst: assert rst_n=0 with level=5 -> m_valid=0, level=0 and credits=8 immediately. Traffic restarted after release completes normally.
